// File: rtl/filterbank_mac.sv
// Time-multiplexed NFILT-channel FIR bank: two taps per filter per cycle over a shared
// circular sample history, followed by a round-half-up / saturate output stage.
module filterbank_mac #(
  parameter int NTAPS  = 128,
  parameter int NFILT  = 8,
  parameter int DW     = 16,
  parameter int CW     = 18,
  parameter int OW     = 16,
  parameter int OSHIFT = 17,
  localparam int AW    = DW + CW + $clog2(NTAPS),
  localparam int AAW   = $clog2(NTAPS / 2)
) (
  input  logic                  clock,
  input  logic                  resetn,
  input  logic [DW-1:0]         datain,
  input  logic                  din_enable,
  output logic [AAW-1:0]        coeffaddress,
  input  logic [NFILT*2*CW-1:0] coeffdata,
  output logic [NFILT*OW-1:0]   dataout,
  output logic                  dout_valid,
  output logic                  busy,
  output logic                  overrun
);

  localparam int PW  = $clog2(NTAPS);
  localparam int PRW = DW + CW;
  localparam logic [AAW-1:0]     LAST_ADDR = AAW'(NTAPS / 2 - 1);
  localparam logic signed [AW:0] RND  = {{(AW - OSHIFT + 1){1'b0}}, 1'b1, {(OSHIFT - 1){1'b0}}};
  localparam logic signed [AW:0] OMAX = {{(AW - OW + 2){1'b0}}, {(OW - 1){1'b1}}};
  localparam logic signed [AW:0] OMIN = ~OMAX;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t                state_q, state_d;
  logic [AAW-1:0]        addr_q, addr_d;
  logic [1:0]            drain_q, drain_d;
  logic [PW-1:0]         wp_q, wp_d;
  logic [DW-1:0]         hist_q [NTAPS];
  logic [DW-1:0]         hist_d [NTAPS];
  logic                  overrun_q, overrun_d;
  logic                  accept;
  logic [PW:0]           idx_base;
  logic [PW-1:0]         idx0, idx1;

  logic                  v1_q, v1_d, v2_q, v2_d, v3_q, v3_d;
  logic signed [DW-1:0]  s1a_q, s1a_d, s1b_q, s1b_d;
  logic signed [DW-1:0]  s2a_q, s2a_d, s2b_q, s2b_d;
  logic [NFILT*2*CW-1:0] coef_q, coef_d;
  logic signed [PRW-1:0] plo_q [NFILT];
  logic signed [PRW-1:0] plo_d [NFILT];
  logic signed [PRW-1:0] phi_q [NFILT];
  logic signed [PRW-1:0] phi_d [NFILT];
  logic signed [AW-1:0]  acc_q [NFILT];
  logic signed [AW-1:0]  acc_d [NFILT];
  logic [NFILT*OW-1:0]   dout_q, dout_d;
  logic                  dv_q, dv_d;

  function automatic logic [OW-1:0] round_sat(input logic signed [AW-1:0] a);
    logic signed [AW:0] r;
    r = ((AW + 1)'(a) + RND) >>> OSHIFT;
    if (r > OMAX)      return OMAX[OW-1:0];
    else if (r < OMIN) return OMIN[OW-1:0];
    else               return r[OW-1:0];
  endfunction

  assign busy   = (state_q != S_IDLE);
  assign accept = din_enable && (state_q == S_IDLE);

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    drain_d = drain_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          state_d = S_RUN;
          addr_d  = '0;
        end
      end
      S_RUN: begin
        if (addr_q == LAST_ADDR) begin
          state_d = S_DRAIN;
          addr_d  = '0;
          drain_d = '0;
        end else begin
          addr_d = addr_q + AAW'(1);
        end
      end
      S_DRAIN: begin
        if (drain_q == 2'd2) state_d = S_DONE;
        else                 drain_d = drain_q + 2'd1;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Newest sample sits just behind the write pointer; address a reads x[n-2a] and x[n-1-2a].
  always_comb begin
    idx_base = {1'b0, wp_q} + (PW + 1)'(NTAPS - 1) - (PW + 1)'({addr_q, 1'b0});
    if (idx_base >= (PW + 1)'(NTAPS)) idx_base = idx_base - (PW + 1)'(NTAPS);
    idx0 = idx_base[PW-1:0];
    idx1 = (idx0 == '0) ? PW'(NTAPS - 1) : idx0 - PW'(1);
  end

  always_comb begin
    hist_d = hist_q;
    wp_d   = wp_q;
    if (accept) begin
      hist_d[wp_q] = datain;
      wp_d = (wp_q == PW'(NTAPS - 1)) ? '0 : wp_q + PW'(1);
    end
  end

  assign overrun_d = overrun_q | (din_enable & busy);

  // Sample taps are delayed two stages to line up with the registered memory output.
  always_comb begin
    v1_d   = (state_q == S_RUN);
    s1a_d  = hist_q[idx0];
    s1b_d  = hist_q[idx1];
    v2_d   = v1_q;
    s2a_d  = s1a_q;
    s2b_d  = s1b_q;
    coef_d = coeffdata;
    v3_d   = v2_q;
    for (int f = 0; f < NFILT; f++) begin
      plo_d[f] = PRW'(s2a_q) * PRW'($signed(coef_q[f*2*CW +: CW]));
      phi_d[f] = PRW'(s2b_q) * PRW'($signed(coef_q[f*2*CW+CW +: CW]));
    end
  end

  always_comb begin
    acc_d  = acc_q;
    dout_d = dout_q;
    dv_d   = (state_q == S_DONE);
    for (int f = 0; f < NFILT; f++) begin
      if (accept)    acc_d[f] = '0;
      else if (v3_q) acc_d[f] = acc_q[f] + AW'(plo_q[f]) + AW'(phi_q[f]);
      if (state_q == S_DONE) dout_d[f*OW +: OW] = round_sat(acc_q[f]);
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q   <= S_IDLE;
      addr_q    <= '0;
      drain_q   <= '0;
      wp_q      <= '0;
      overrun_q <= 1'b0;
      for (int i = 0; i < NTAPS; i++) hist_q[i] <= '0;
      v1_q      <= 1'b0;
      v2_q      <= 1'b0;
      v3_q      <= 1'b0;
      s1a_q     <= '0;
      s1b_q     <= '0;
      s2a_q     <= '0;
      s2b_q     <= '0;
      coef_q    <= '0;
      for (int f = 0; f < NFILT; f++) begin
        plo_q[f] <= '0;
        phi_q[f] <= '0;
        acc_q[f] <= '0;
      end
      dout_q    <= '0;
      dv_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      drain_q   <= drain_d;
      wp_q      <= wp_d;
      overrun_q <= overrun_d;
      hist_q    <= hist_d;
      v1_q      <= v1_d;
      v2_q      <= v2_d;
      v3_q      <= v3_d;
      s1a_q     <= s1a_d;
      s1b_q     <= s1b_d;
      s2a_q     <= s2a_d;
      s2b_q     <= s2b_d;
      coef_q    <= coef_d;
      plo_q     <= plo_d;
      phi_q     <= phi_d;
      acc_q     <= acc_d;
      dout_q    <= dout_d;
      dv_q      <= dv_d;
    end
  end

  assign coeffaddress = addr_q;
  assign dataout      = dout_q;
  assign dout_valid   = dv_q;
  assign overrun      = overrun_q;

endmodule

// File: tb/tb_filterbank_mac.sv
// Self-checking bench for filterbank_mac: default-size instance plus an NTAPS=8/NFILT=2 instance,
// each checked against a direct convolution model over the accepted-sample history.
module tb_filterbank_mac;

  localparam int NT = 128, NF = 8, NT2 = 8, NF2 = 2;
  localparam int DW = 16, CW = 18, OW = 16, OSH = 17;
  localparam int LAT1 = NT / 2 + 4, LAT2 = NT2 / 2 + 4;

  logic                  clock, resetn;
  logic [DW-1:0]         din1, din2;
  logic                  en1, en2;
  logic [5:0]            ca1;
  logic [1:0]            ca2;
  logic [NF*2*CW-1:0]    cd1;
  logic [NF2*2*CW-1:0]   cd2;
  logic [NF*OW-1:0]      do1;
  logic [NF2*OW-1:0]     do2;
  logic                  dv1, dv2, busy1, busy2, ovr1, ovr2;

  int h1 [NF][NT];
  int h2 [NF2][NT2];
  int hq1 [$];
  int hq2 [$];
  int nCompared = 0, nMismatched = 0;

  typedef struct { bit rst; int mode; int x; int exp; } vec_t;
  vec_t tbl [12];

  filterbank_mac dut1 (
    .clock(clock), .resetn(resetn), .datain(din1), .din_enable(en1),
    .coeffaddress(ca1), .coeffdata(cd1), .dataout(do1),
    .dout_valid(dv1), .busy(busy1), .overrun(ovr1)
  );

  filterbank_mac #(.NTAPS(NT2), .NFILT(NF2)) dut2 (
    .clock(clock), .resetn(resetn), .datain(din2), .din_enable(en2),
    .coeffaddress(ca2), .coeffdata(cd2), .dataout(do2),
    .dout_valid(dv2), .busy(busy2), .overrun(ovr2)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Synchronous coefficient memories with one cycle of read latency.
  always @(posedge clock) begin
    for (int f = 0; f < NF; f++) begin
      cd1[f*2*CW +: CW]    <= CW'(h1[f][2*ca1]);
      cd1[f*2*CW+CW +: CW] <= CW'(h1[f][2*ca1+1]);
    end
    for (int f = 0; f < NF2; f++) begin
      cd2[f*2*CW +: CW]    <= CW'(h2[f][2*ca2]);
      cd2[f*2*CW+CW +: CW] <= CW'(h2[f][2*ca2+1]);
    end
  end

  initial begin
    #5000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  function automatic int randCoef();
    return int'($urandom_range(0, 2**CW - 1)) - 2**(CW - 1);
  endfunction

  function automatic longint roundSat(longint a);
    longint r;
    r = (a + (longint'(1) <<< (OSH - 1))) >>> OSH;
    if (r > 2**(OW-1) - 1) r = 2**(OW-1) - 1;
    else if (r < -(2**(OW-1))) r = -(2**(OW-1));
    return r;
  endfunction

  function automatic longint refOut1(int f);
    longint acc = 0;
    for (int k = 0; k < hq1.size(); k++) acc += longint'(h1[f][k]) * longint'(hq1[k]);
    return roundSat(acc);
  endfunction

  function automatic longint refOut2(int f);
    longint acc = 0;
    for (int k = 0; k < hq2.size(); k++) acc += longint'(h2[f][k]) * longint'(hq2[k]);
    return roundSat(acc);
  endfunction

  function automatic longint outWord1(int f);
    return longint'($signed(do1[f*OW +: OW]));
  endfunction

  function automatic longint outWord2(int f);
    return longint'($signed(do2[f*OW +: OW]));
  endfunction

  task automatic checkOutput(input string name, input longint got, input longint exp);
    nCompared++;
    if (got != exp) begin
      nMismatched++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, got, exp);
    end
  endtask

  task automatic setRandom1();
    for (int f = 0; f < NF; f++)
      for (int k = 0; k < NT; k++) h1[f][k] = randCoef();
  endtask

  task automatic doReset();
    @(negedge clock);
    resetn = 1'b0; en1 = 1'b0; en2 = 1'b0;
    repeat (2) @(negedge clock);
    resetn = 1'b1;
    hq1.delete();
    hq2.delete();
  endtask

  // Drives one sample starting at a negedge; returns at the negedge of the dout_valid cycle.
  task automatic applyStimulus(input int x, input bit chkAddr, input string tag);
    int j;
    bit seen;
    din1 = DW'(x); en1 = 1'b1;
    @(posedge clock);
    hq1.push_front(x);
    if (hq1.size() > NT) void'(hq1.pop_back());
    @(negedge clock);
    en1 = 1'b0;
    seen = 1'b0; j = 1;
    while (!seen && j <= 3 * LAT1) begin
      if (chkAddr && j <= NT / 2 + 1)
        checkOutput($sformatf("%s_addr%0d", tag, j - 1), ca1, (j <= NT / 2) ? j - 1 : 0);
      if (dv1) seen = 1'b1;
      else begin
        @(negedge clock);
        j++;
      end
    end
    checkOutput({tag, "_latency"}, seen ? j - 1 : -1, LAT1);
    if (seen)
      for (int f = 0; f < NF; f++)
        checkOutput($sformatf("%s_f%0d", tag, f), outWord1(f), refOut1(f));
  endtask

  task automatic applyStimulus2(input int x, input bit chkAddr, input string tag);
    int j;
    bit seen;
    din2 = DW'(x); en2 = 1'b1;
    @(posedge clock);
    hq2.push_front(x);
    if (hq2.size() > NT2) void'(hq2.pop_back());
    @(negedge clock);
    en2 = 1'b0;
    seen = 1'b0; j = 1;
    while (!seen && j <= 3 * LAT2) begin
      if (chkAddr && j <= NT2 / 2 + 1)
        checkOutput($sformatf("%s_addr%0d", tag, j - 1), ca2, (j <= NT2 / 2) ? j - 1 : 0);
      if (dv2) seen = 1'b1;
      else begin
        @(negedge clock);
        j++;
      end
    end
    checkOutput({tag, "_latency"}, seen ? j - 1 : -1, LAT2);
    if (seen)
      for (int f = 0; f < NF2; f++)
        checkOutput($sformatf("%s_f%0d", tag, f), outWord2(f), refOut2(f));
  endtask

  initial begin
    int pulses, first;

    // mode 0: filter 0 is a unit-ish impulse on tap 0; mode 1: every tap of every filter at max
    tbl[0]  = '{1'b1, 0, 1, 1};
    tbl[1]  = '{1'b0, 0, -1, 0};
    tbl[2]  = '{1'b0, 0, 3, 2};
    tbl[3]  = '{1'b0, 0, -3, -1};
    tbl[4]  = '{1'b0, 0, 100, 50};
    tbl[5]  = '{1'b0, 0, -32768, -16384};
    tbl[6]  = '{1'b0, 0, 32767, 16384};
    tbl[7]  = '{1'b1, 1, 32767, 32767};
    tbl[8]  = '{1'b0, 1, 32767, 32767};
    tbl[9]  = '{1'b0, 1, 32767, 32767};
    tbl[10] = '{1'b1, 1, -32768, -32768};
    tbl[11] = '{1'b0, 1, -32768, -32768};

    resetn = 1'b0; en1 = 1'b0; en2 = 1'b0; din1 = '0; din2 = '0;
    repeat (3) @(negedge clock);
    checkOutput("rst_dataout_nonzero", longint'(do1 != '0), 0);
    checkOutput("rst_dout_valid", dv1, 0);
    checkOutput("rst_busy", busy1, 0);
    checkOutput("rst_overrun", ovr1, 0);
    checkOutput("rst_coeffaddress", ca1, 0);
    checkOutput("rst_busy_small", busy2, 0);
    resetn = 1'b1;

    // Small instance: ramp through several pointer wraps, only tap 7 of filter 0 non-zero.
    for (int f = 0; f < NF2; f++)
      for (int k = 0; k < NT2; k++) h2[f][k] = (f == 0) ? 0 : randCoef();
    h2[0][7] = 65536;
    for (int n = 1; n <= 20; n++) begin
      applyStimulus2(n, n <= 2, $sformatf("wrap_n%0d", n));
      checkOutput($sformatf("wrap_const_n%0d", n), outWord2(0), (n < 8) ? 0 : (n - 6) / 2);
    end

    // Impulse response with 70-cycle sample spacing.
    setRandom1();
    for (int k = 0; k < NT; k++) begin
      h1[0][k] = 65536;
      h1[1][k] = k * 256;
    end
    for (int r = 0; r <= NT; r++) begin
      applyStimulus((r == 0) ? 16384 : 0, r == 0, $sformatf("imp_r%0d", r));
      checkOutput($sformatf("imp_const_f0_r%0d", r), outWord1(0), (r < NT) ? 8192 : 0);
      checkOutput($sformatf("imp_const_f1_r%0d", r), outWord1(1), (r < NT) ? 32 * r : 0);
      @(negedge clock);
      checkOutput($sformatf("imp_pulse_r%0d", r), dv1, 0);
      checkOutput($sformatf("imp_hold_r%0d", r), outWord1(0), (r < NT) ? 8192 : 0);
    end

    // Random samples and coefficients with random idle gaps.
    setRandom1();
    for (int i = 0; i < 20; i++) begin
      applyStimulus(int'($urandom_range(0, 65535)) - 32768, 1'b0, $sformatf("rand%0d", i));
      repeat ($urandom_range(0, 3)) @(negedge clock);
    end

    // Rounding and saturation vectors.
    for (int i = 0; i < 12; i++) begin
      if (tbl[i].rst) doReset();
      if (tbl[i].mode == 0) begin
        setRandom1();
        for (int k = 0; k < NT; k++) h1[0][k] = 0;
        h1[0][0] = 65536;
      end else begin
        for (int f = 0; f < NF; f++)
          for (int k = 0; k < NT; k++) h1[f][k] = 131071;
      end
      applyStimulus(tbl[i].x, 1'b0, $sformatf("tbl%0d", i));
      for (int f = 0; f < ((tbl[i].mode == 0) ? 1 : NF); f++)
        checkOutput($sformatf("tbl%0d_const_f%0d", i, f), outWord1(f), tbl[i].exp);
    end

    // Overrun: second strobe three cycles after an accepted one is dropped.
    doReset();
    setRandom1();
    din1 = DW'(1234); en1 = 1'b1;
    @(posedge clock);
    hq1.push_front(1234);
    @(negedge clock);
    en1 = 1'b0;
    repeat (2) @(negedge clock);
    din1 = DW'(-999); en1 = 1'b1;
    @(negedge clock);
    en1 = 1'b0;
    checkOutput("ovr_flag", ovr1, 1);
    pulses = 0; first = -1;
    for (int j = 4; j <= 200; j++) begin
      if (dv1) begin
        pulses++;
        if (first < 0) begin
          first = j - 1;
          for (int f = 0; f < NF; f++)
            checkOutput($sformatf("ovr_f%0d", f), outWord1(f), refOut1(f));
        end
      end
      @(negedge clock);
    end
    checkOutput("ovr_pulses", pulses, 1);
    checkOutput("ovr_latency", first, LAT1);
    applyStimulus(-20000, 1'b0, "b2b_a");
    applyStimulus(31000, 1'b0, "b2b_b");
    checkOutput("ovr_sticky", ovr1, 1);

    // Reset asserted mid-computation.
    setRandom1();
    din1 = DW'(5000); en1 = 1'b1;
    @(posedge clock);
    @(negedge clock);
    en1 = 1'b0;
    checkOutput("mid_busy_before", busy1, 1);
    repeat (9) @(negedge clock);
    @(posedge clock);
    #1 resetn = 1'b0;
    #1;
    checkOutput("mid_busy", busy1, 0);
    checkOutput("mid_overrun", ovr1, 0);
    checkOutput("mid_dout_valid", dv1, 0);
    checkOutput("mid_dataout_nonzero", longint'(do1 != '0), 0);
    checkOutput("mid_coeffaddress", ca1, 0);
    repeat (2) @(negedge clock);
    resetn = 1'b1;
    hq1.delete();
    hq2.delete();
    pulses = 0;
    repeat (80) begin
      @(negedge clock);
      if (dv1) pulses++;
    end
    checkOutput("mid_no_valid", pulses, 0);
    for (int f = 0; f < NF; f++)
      for (int k = 0; k < NT; k++) h1[f][k] = 65536;
    applyStimulus(16384, 1'b1, "post_rst");
    for (int f = 0; f < NF; f++)
      checkOutput($sformatf("post_rst_const_f%0d", f), outWord1(f), 8192);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
